lcd_seq_ctrl: RTL and testbench
===============================

LCD_SEQ_CTRL -- requirements
Module: lcd_seq_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 1000: clk cycles panel reset is held low.
REQ-002 Parameter GAP_CYCLES, default 1023: idle clk cycles between consecutive bytes.
REQ-003 Parameter FRAME_BYTES, default 504: data bytes per frame (84x48 / 8).
REQ-004 Parameter HB_CYCLES, default 100_000_000: heartbeat half-period in clk cycles.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rstb  input  1  synchronous active-low reset.
REQ-007 frame_req  input  1  one-cycle pulse requesting a frame refresh.
REQ-008 spi_start  output  1  one-cycle pulse launching one byte on the SPI byte master.
REQ-009 spi_tdat  output  8  byte to transmit; stable from spi_start until spi_done.
REQ-010 spi_done  input  1  one-cycle pulse from the SPI byte master: byte complete.
REQ-011 fb_addr  output  9  frame-buffer read address; read data valid one cycle later.
REQ-012 fb_data  input  8  frame-buffer read data.
REQ-013 lcd_rst  output  1  panel reset, active-low.
REQ-014 dc  output  1  panel data/command select: 0 = command, 1 = data.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 frame_done  output  1  one-cycle pulse after the last data byte's spi_done.
REQ-017 led  output  1  heartbeat (see Configuration).

Function
REQ-018 FSM states: RST, INIT_SEND, INIT_WAIT, GAP, IDLE, CUR_SEND, CUR_WAIT, FETCH, DATA_SEND, DATA_WAIT.
REQ-019 RST: lcd_rst=0 for RST_CYCLES cycles, then lcd_rst=1 and go to INIT_SEND with cmd index 0.
REQ-020 Init list: 8 fixed bytes, in order 0x21, 0xC6, 0x04, 0x14, 0x20, 0x0C, 0x40, 0x80, all with dc=0.
REQ-021 *_SEND: spi_tdat and dc set and spi_start=1 for exactly one cycle; next state is the matching *_WAIT.
REQ-022 *_WAIT: hold until spi_done=1; then go to GAP with the successor state recorded.
REQ-023 GAP: count GAP_CYCLES cycles, then enter the recorded successor; GAP_CYCLES=0 means zero gap cycles.
REQ-024 After the 8th init byte's GAP, go to IDLE; led heartbeat and frame_req handling run only from here on.
REQ-025 IDLE: frame_req, or the pending flag set, starts a frame: CUR_SEND 0x40 then 0x80 (dc=0), then FETCH.
REQ-026 FETCH: drive fb_addr = data index; one cycle later go to DATA_SEND with spi_tdat=fb_data and dc=1.
REQ-027 Data index runs 0..FRAME_BYTES-1; after the last byte's spi_done, pulse frame_done, clear the index to 0 and go to IDLE (no gap).
REQ-028 frame_req while busy=1 sets a single pending flag; multiple requests collapse into one; the flag clears when its frame starts.
REQ-029 frame_req in the same cycle as frame_done: the new frame starts from IDLE on the following cycle.
REQ-030 spi_done outside a *_WAIT state is ignored; spi_start is never reasserted before spi_done.
REQ-031 dc changes only in a *_SEND cycle, never while a byte is in flight.

Reset
REQ-032 rstb=0 at any clk edge, including mid-byte: next state RST, lcd_rst=0, spi_start=0, spi_tdat=0x00, dc=0, fb_addr=0, busy=1, frame_done=0, led=1; counters, indices and pending flag cleared.
REQ-033 After rstb returns to 1, the full reset and init sequence re-runs before any frame is sent.

Configuration
REQ-034 Macro LCD_SEQ_HEARTBEAT_EN defined: led toggles every HB_CYCLES cycles while not in reset.
REQ-035 Macro LCD_SEQ_HEARTBEAT_EN undefined: no heartbeat counter is built and led is tied to 1.

Verification
REQ-036 Release rstb, RST_CYCLES=4, GAP_CYCLES=2, SPI model returning done 8 cycles after start -> lcd_rst low 4 cycles; 8 spi_start pulses carrying 21,C6,04,14,20,0C,40,80 with dc=0; then IDLE with busy=0.
REQ-037 frame_req in IDLE with FRAME_BYTES=4 and frame buffer holding 11,22,33,44 -> bytes 40,80 with dc=0, then 11,22,33,44 with dc=1, then one frame_done pulse.
REQ-038 Three frame_req pulses during a frame -> exactly one extra frame follows.
REQ-039 rstb=0 during DATA_WAIT -> next cycle lcd_rst=0, spi_start=0, busy=1; after release, the init sequence repeats from 0x21.
REQ-040 Spurious spi_done in IDLE and GAP -> no state change and no spi_start.
REQ-041 With LCD_SEQ_HEARTBEAT_EN and HB_CYCLES=5 -> led toggles every 5 cycles; without the macro -> led constant 1.

Source files
------------

// File: rtl/lcd_seq_if.sv
// lcd_seq_if: SPI byte-master handshake and frame-buffer read port of lcd_seq_ctrl.
interface lcd_seq_if;
    logic       spi_start;
    logic [7:0] spi_tdat;
    logic       spi_done;
    logic [8:0] fb_addr;
    logic [7:0] fb_data;
    modport master (output spi_start, spi_tdat, fb_addr, input spi_done, fb_data);
    modport slave  (input spi_start, spi_tdat, fb_addr, output spi_done, fb_data);
endinterface

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: panel reset, init command list and frame streaming for an 84x48 LCD.
// Optional heartbeat on led is built only with LCD_SEQ_HEARTBEAT_EN defined.
module lcd_seq_ctrl #(
    parameter int RST_CYCLES  = 1000,
    parameter int GAP_CYCLES  = 1023,
    parameter int FRAME_BYTES = 504,
    parameter int HB_CYCLES   = 100_000_000
) (
    input  logic      clk,
    input  logic      rstb,
    input  logic      frame_req,
    lcd_seq_if.master bus,
    output logic      lcd_rst,
    output logic      dc,
    output logic      busy,
    output logic      frame_done,
    output logic      led
);
    typedef enum logic [3:0] {
        RST, INIT_SEND, INIT_WAIT, GAP, IDLE, CUR_SEND, CUR_WAIT, FETCH, DATA_SEND, DATA_WAIT
    } state_t;
    localparam int RST_LAST = RST_CYCLES > 0 ? RST_CYCLES - 1 : 0;
    localparam int GAP_LAST = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
    localparam bit HAS_GAP = GAP_CYCLES != 0;
    localparam logic [7:0] INIT [8] = '{8'h21, 8'hC6, 8'h04, 8'h14, 8'h20, 8'h0C, 8'h40, 8'h80};
    state_t      state, nxt, ret, ret_n;
    logic [31:0] cnt;
    logic [2:0]  ci;
    logic [8:0]  di;
    logic        cur, pend, run, fd, dc_q, last;
    logic [7:0]  tdat_q;
    assign last = di == 9'(FRAME_BYTES - 1);
    always_ff @(posedge clk)
        state <= !rstb ? RST : nxt;
    always_comb begin
        nxt   = state;
        ret_n = ret;
        case (state)
            RST:       nxt = cnt == 32'(RST_LAST) ? INIT_SEND : RST;
            INIT_SEND: nxt = INIT_WAIT;
            INIT_WAIT: if (bus.spi_done) begin
                ret_n = ci == 3'd7 ? IDLE : INIT_SEND;
                nxt   = HAS_GAP ? GAP : ret_n;
            end
            GAP:       nxt = cnt == 32'(GAP_LAST) ? ret : GAP;
            IDLE:      nxt = (frame_req || pend) ? CUR_SEND : IDLE;
            CUR_SEND:  nxt = CUR_WAIT;
            CUR_WAIT:  if (bus.spi_done) begin
                ret_n = cur ? FETCH : CUR_SEND;
                nxt   = HAS_GAP ? GAP : ret_n;
            end
            FETCH:     nxt = DATA_SEND;
            DATA_SEND: nxt = DATA_WAIT;
            DATA_WAIT: if (bus.spi_done) begin
                ret_n = FETCH;
                nxt   = last ? IDLE : HAS_GAP ? GAP : FETCH;
            end
            default:   nxt = RST;
        endcase
    end
    always_comb begin
        bus.spi_start = state == INIT_SEND || state == CUR_SEND || state == DATA_SEND;
        bus.spi_tdat  = state == INIT_SEND ? INIT[ci] :
                        state == CUR_SEND  ? (cur ? 8'h80 : 8'h40) :
                        state == DATA_SEND ? bus.fb_data : tdat_q;
        dc            = state == DATA_SEND ? 1'b1 :
                        (state == INIT_SEND || state == CUR_SEND) ? 1'b0 : dc_q;
        bus.fb_addr   = di;
        lcd_rst       = state != RST;
        busy          = state != IDLE;
        frame_done    = fd;
    end
    // tdat_q/dc_q hold the last launched byte so the bus stays stable while it is in flight
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt    <= '0;
            ci     <= '0;
            di     <= '0;
            cur    <= 1'b0;
            pend   <= 1'b0;
            run    <= 1'b0;
            fd     <= 1'b0;
            tdat_q <= '0;
            dc_q   <= 1'b0;
            ret    <= IDLE;
        end else begin
            cnt  <= (state == nxt && (state == RST || state == GAP)) ? cnt + 32'd1 : '0;
            ret  <= ret_n;
            pend <= state == IDLE ? 1'b0 : pend | (frame_req & run);
            fd   <= state == DATA_WAIT && bus.spi_done && last;
            if (nxt == IDLE) run <= 1'b1;
            if (state == INIT_WAIT && bus.spi_done) ci <= ci + 3'd1;
            if (state == CUR_WAIT && bus.spi_done) cur <= ~cur;
            if (state == DATA_WAIT && bus.spi_done) di <= last ? '0 : di + 9'd1;
            if (bus.spi_start) begin
                tdat_q <= bus.spi_tdat;
                dc_q   <= dc;
            end
        end
    end
`ifdef LCD_SEQ_HEARTBEAT_EN
    logic [31:0] hb;
    logic        led_q;
    always_ff @(posedge clk) begin
        if (!rstb) begin
            hb    <= '0;
            led_q <= 1'b1;
        end else if (run) begin
            hb    <= hb == 32'(HB_CYCLES - 1) ? '0 : hb + 32'd1;
            led_q <= hb == 32'(HB_CYCLES - 1) ? ~led_q : led_q;
        end
    end
    assign led = led_q;
`else
    assign led = 1'b1 | (HB_CYCLES == 0);
`endif
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: directed bench with an 8-cycle SPI byte model and a 1-cycle frame buffer.
module tb_lcd_seq_ctrl;
    logic clk = 0, rstb = 0, frame_req = 0;
    logic lcd_rst, dc, busy, frame_done, led;
    logic md = 0, spur = 0, dcl = 0;
    logic [7:0] fbd = 0;
    logic [7:0] mem [512];
    logic [8:0] q [$];
    int cd = 0, tests = 0, fails = 0;
    localparam logic [8:0] INITB [8] = '{9'h021, 9'h0C6, 9'h004, 9'h014, 9'h020, 9'h00C, 9'h040, 9'h080};
    localparam logic [8:0] FRAME [6] = '{9'h040, 9'h080, 9'h111, 9'h122, 9'h133, 9'h144};
    lcd_seq_if bus();
    assign bus.spi_done = md | spur;
    assign bus.fb_data  = fbd;
    lcd_seq_ctrl #(.RST_CYCLES(4), .GAP_CYCLES(2), .FRAME_BYTES(4), .HB_CYCLES(5)) dut (
        .clk(clk), .rstb(rstb), .frame_req(frame_req), .bus(bus),
        .lcd_rst(lcd_rst), .dc(dc), .busy(busy), .frame_done(frame_done), .led(led)
    );
    always #5 clk = ~clk;
    initial begin
        forever begin
            logic [8:0] a;
            @(negedge clk);
            a = bus.fb_addr;
            @(posedge clk);
            #1 fbd = mem[a];
        end
    end
    // SPI byte model and byte logger: done arrives 8 cycles after start
    initial begin
        forever begin
            @(negedge clk);
            if (!rstb) begin
                cd = 0;
                md = 0;
            end else begin
                md = 0;
                if (cd != 0) begin
                    tests++;
                    if (bus.spi_start !== 1'b0 || dc !== dcl) begin
                        fails++;
                        $display("FAIL inflight: spi_start=%b dc=%b, required spi_start=0 dc=%b", bus.spi_start, dc, dcl);
                    end
                    cd--;
                    md = cd == 0;
                end else if (bus.spi_start) begin
                    q.push_back({dc, bus.spi_tdat});
                    dcl = dc;
                    cd = 8;
                end
            end
        end
    end
    task automatic pulse_req;
        frame_req = 1;
        @(negedge clk);
        frame_req = 0;
    endtask
    task automatic run(input int n, output int fds);
        fds = 0;
        repeat (n) begin
            @(negedge clk);
            if (frame_done) fds++;
        end
    endtask
    task automatic wait_idle(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask
    task automatic test_reset;
        int k;
        rstb = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({lcd_rst, bus.spi_start, busy, dc, frame_done, led} !== 6'b001001) begin
            fails++;
            $display("FAIL reset_ctrl: lcd_rst,start,busy,dc,fd,led=%b required 001001",
                     {lcd_rst, bus.spi_start, busy, dc, frame_done, led});
        end
        tests++;
        if (bus.spi_tdat !== 8'h00 || bus.fb_addr !== 9'd0) begin
            fails++;
            $display("FAIL reset_bus: tdat=%h addr=%0d required 00 0", bus.spi_tdat, bus.fb_addr);
        end
        q.delete();
        rstb = 1;
        k = 0;
        while (lcd_rst !== 1'b1 && k < 50) begin
            k++;
            @(negedge clk);
        end
        tests++;
        if (k != 4) begin
            fails++;
            $display("FAIL rst_len: lcd_rst low %0d cycles required 4", k);
        end
    endtask
    task automatic test_init(input string nm);
        bit ok;
        wait_idle(2000, ok);
        tests++;
        if (!ok || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: busy=%b required 0", nm, busy);
        end
        tests++;
        if (q.size() != 8) begin
            fails++;
            $display("FAIL %s_count: %0d bytes required 8", nm, q.size());
        end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= q.size() || q[i] !== INITB[i]) begin
                fails++;
                $display("FAIL %s_byte%0d: dc,byte=%h required %h", nm, i, i < q.size() ? q[i] : 9'h1ff, INITB[i]);
            end
        end
    endtask
    task automatic check_frames(input string nm, input int n, input int fds);
        tests++;
        if (fds != n || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: frame_done=%0d busy=%b required %0d 0", nm, fds, busy, n);
        end
        tests++;
        if (q.size() != 6 * n) begin
            fails++;
            $display("FAIL %s_count: %0d bytes required %0d", nm, q.size(), 6 * n);
        end
        for (int i = 0; i < 6 * n; i++) begin
            tests++;
            if (i >= q.size() || q[i] !== FRAME[i % 6]) begin
                fails++;
                $display("FAIL %s_byte%0d: dc,byte=%h required %h", nm, i, i < q.size() ? q[i] : 9'h1ff, FRAME[i % 6]);
            end
        end
    endtask
    task automatic test_frame;
        int fds;
        q.delete();
        pulse_req();
        run(250, fds);
        check_frames("frame", 1, fds);
    endtask
    task automatic test_pending;
        int f, tot;
        q.delete();
        pulse_req();
        run(30, tot);
        repeat (3) begin
            pulse_req();
            run(5, f);
            tot += f;
        end
        run(400, f);
        check_frames("pending", 2, tot + f);
    endtask
    task automatic test_back_to_back;
        int fds;
        bit got = 0;
        q.delete();
        pulse_req();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1;
                break;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL b2b_wait: no frame_done within 300 cycles");
        end
        q.delete();
        pulse_req();
        tests++;
        if (bus.spi_start !== 1'b1 || bus.spi_tdat !== 8'h40 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_start: start=%b tdat=%h busy=%b required 1 40 1", bus.spi_start, bus.spi_tdat, busy);
        end
        run(250, fds);
        check_frames("b2b", 1, fds);
    endtask
    task automatic test_spurious;
        int fds;
        bit got = 0;
        q.delete();
        spur = 1;
        @(negedge clk);
        spur = 0;
        run(10, fds);
        tests++;
        if (busy !== 1'b0 || q.size() != 0) begin
            fails++;
            $display("FAIL spur_idle: busy=%b starts=%0d required 0 0", busy, q.size());
        end
        pulse_req();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (md) begin
                got = 1;
                break;
            end
        end
        @(negedge clk);
        spur = 1;
        @(negedge clk);
        spur = 0;
        tests++;
        if (!got || bus.spi_start !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL spur_gap: seen=%b start=%b busy=%b required 1 0 1", got, bus.spi_start, busy);
        end
        run(250, fds);
        check_frames("spur", 1, fds);
    endtask
    task automatic test_reset_mid;
        int fds;
        bit got = 0;
        q.delete();
        pulse_req();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.spi_start && dc && bus.spi_tdat == 8'h22) begin
                got = 1;
                break;
            end
        end
        @(negedge clk);
        rstb = 0;
        @(negedge clk);
        tests++;
        if (!got || lcd_rst !== 1'b0 || bus.spi_start !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_ctrl: seen=%b lcd_rst=%b start=%b busy=%b required 1 0 0 1",
                     got, lcd_rst, bus.spi_start, busy);
        end
        tests++;
        if (bus.spi_tdat !== 8'h00 || dc !== 1'b0 || bus.fb_addr !== 9'd0) begin
            fails++;
            $display("FAIL midrst_bus: tdat=%h dc=%b addr=%0d required 00 0 0", bus.spi_tdat, dc, bus.fb_addr);
        end
        q.delete();
        rstb = 1;
        test_init("reinit");
        run(50, fds);
        tests++;
        if (q.size() != 8 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_quiet: %0d bytes busy=%b required 8 0", q.size(), busy);
        end
    endtask
    task automatic test_led;
`ifdef LCD_SEQ_HEARTBEAT_EN
        logic l0;
        int k = 0;
        l0 = led;
        for (int i = 0; i < 20 && led === l0; i++) @(negedge clk);
        l0 = led;
        while (led === l0 && k < 20) begin
            k++;
            @(negedge clk);
        end
        tests++;
        if (k != 5) begin
            fails++;
            $display("FAIL led_period: %0d cycles required 5", k);
        end
`else
        bit ok = 1;
        repeat (12) begin
            @(negedge clk);
            if (led !== 1'b1) ok = 0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL led_const: led left 1 required constant 1");
        end
`endif
    endtask
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;
        test_reset();
        test_init("init");
        test_frame();
        test_pending();
        test_back_to_back();
        test_spurious();
        test_led();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
